// File: rtl/scan_bcd_counter.sv
// Up/down BCD counter with prescaled tick and multiplexed 7-segment scan.
// Define SCAN_BCD_COUNTER_BLANK_EN to blank leading zero digits.
module scan_bcd_counter #(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 5000000,
    parameter int SCAN_DIV = 65536
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   load_val,
    output logic [4*N_DIGITS-1:0]   count,
    output logic                    carry,
    output logic [N_DIGITS-1:0]     sel,
    output logic [6:0]              seg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW = 4 * N_DIGITS;

    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] SEL0 = N_DIGITS'(1);

    logic [PW-1:0]       r_pre;
    logic [SW-1:0]       r_scan;
    logic [IW-1:0]       r_idx;
    logic [DW-1:0]       r_count;
    logic                r_carry;
    logic [N_DIGITS-1:0] r_sel;
    logic [6:0]          r_seg;

    logic                w_tick;
    logic [DW-1:0]       w_inc;
    logic [DW-1:0]       w_dec;
    logic [DW-1:0]       w_load;
    logic                w_inc_wrap;
    logic                w_dec_wrap;
    logic [3:0]          w_digit;
    logic [N_DIGITS-1:0] w_sel;
    logic [6:0]          w_dec7;
    logic [6:0]          w_seg;

    assign w_tick = en && (r_pre == P_LAST);

    // Ripple decimal carry/borrow; the final carry-out flags a full wrap.
    always_comb begin : next_count
        logic       bu;
        logic       bd;
        logic [3:0] d;
        w_inc  = r_count;
        w_dec  = r_count;
        w_load = '0;
        bu     = 1'b1;
        bd     = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            d = r_count[4*i +: 4];
            if (bu) begin
                if (d == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = d + 4'd1;
                    bu = 1'b0;
                end
            end
            if (bd) begin
                if (d == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = d - 4'd1;
                    bd = 1'b0;
                end
            end
            w_load[4*i +: 4] = (load_val[4*i +: 4] > 4'd9)
                             ? 4'd0 : load_val[4*i +: 4];
        end
        w_inc_wrap = bu;
        w_dec_wrap = bd;
    end

    always_comb begin : digit_mux
        w_digit = '0;
        w_sel   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_digit  = r_count[4*i +: 4];
                w_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin : decode7
        w_dec7 = 7'h00;
        unique case (w_digit)
            4'd0:    w_dec7 = 7'h3F;
            4'd1:    w_dec7 = 7'h06;
            4'd2:    w_dec7 = 7'h5B;
            4'd3:    w_dec7 = 7'h4F;
            4'd4:    w_dec7 = 7'h66;
            4'd5:    w_dec7 = 7'h6D;
            4'd6:    w_dec7 = 7'h7D;
            4'd7:    w_dec7 = 7'h07;
            4'd8:    w_dec7 = 7'h7F;
            4'd9:    w_dec7 = 7'h6F;
            default: w_dec7 = 7'h00;
        endcase
    end

`ifdef SCAN_BCD_COUNTER_BLANK_EN
    logic w_blank;

    // Blank when this digit and all more significant digits are zero.
    always_comb begin : blanking
        logic za;
        w_blank = 1'b0;
        za      = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            za = za && (r_count[4*i +: 4] == 4'd0);
            if (r_idx == IW'(i)) begin
                w_blank = za && (i > 0);
            end
        end
    end

    assign w_seg = w_blank ? 7'h00 : w_dec7;
`else
    assign w_seg = w_dec7;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_pre   <= '0;
            r_scan  <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_sel   <= SEL0;
            r_seg   <= 7'h3F;
        end else begin
            if (r_scan == S_LAST) begin
                r_scan <= '0;
                r_idx  <= (r_idx == I_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_scan <= r_scan + SW'(1);
            end
            r_sel <= w_sel;
            r_seg <= w_seg;
            if (load) begin
                r_count <= w_load;
                r_pre   <= '0;
                r_carry <= 1'b0;
            end else begin
                if (en) begin
                    r_pre <= w_tick ? '0 : r_pre + PW'(1);
                end
                r_carry <= 1'b0;
                if (w_tick) begin
                    if (up) begin
                        r_count <= w_inc;
                        r_carry <= w_inc_wrap;
                    end else begin
                        r_count <= w_dec;
                        r_carry <= w_dec_wrap;
                    end
                end
            end
        end
    end

    assign count = r_count;
    assign carry = r_carry;
    assign sel   = r_sel;
    assign seg   = r_seg;

endmodule

// File: tb/tb_scan_bcd_counter.sv
// Randomised plus directed bench for scan_bcd_counter against an
// integer-valued reference model.
module tb_scan_bcd_counter;

    localparam int ND = 4;
    localparam int TD = 2;
    localparam int SD = 4;
    localparam int MODV = 10000;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          up = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   load_val = '0;
    logic [15:0]   count;
    logic          carry;
    logic [3:0]    sel;
    logic [6:0]    seg;

    int n_checks = 0;
    int n_fail = 0;

    int       m_val, m_pre, m_scan, m_idx;
    bit       m_carry;
    int       m_sel;
    int       m_seg;

    scan_bcd_counter #(
        .N_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(count),
        .carry(carry), .sel(sel), .seg(seg)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic int seg_of(input int d);
        case (d)
            0: return 'h3F; 1: return 'h06; 2: return 'h5B;
            3: return 'h4F; 4: return 'h66; 5: return 'h6D;
            6: return 'h7D; 7: return 'h07; 8: return 'h7F;
            9: return 'h6F;
            default: return 0;
        endcase
    endfunction

    function automatic int sanitize(input logic [15:0] lv);
        int v = 0;
        int d;
        for (int k = 0; k < ND; k++) begin
            d = int'(lv[4*k +: 4]);
            if (d > 9) d = 0;
            v += d * pow10(k);
        end
        return v;
    endfunction

    task automatic model_step();
        bit tick;
        int n_sel, n_seg;
        tick  = en && (m_pre == TD - 1);
        n_sel = 1 << m_idx;
        n_seg = seg_of((m_val / pow10(m_idx)) % 10);
`ifdef SCAN_BCD_COUNTER_BLANK_EN
        if (m_idx > 0 && m_val < pow10(m_idx)) n_seg = 0;
`endif
        if (reset) begin
            m_val = 0; m_pre = 0; m_scan = 0; m_idx = 0;
            m_carry = 0; m_sel = 1; m_seg = 'h3F;
        end else begin
            if (m_scan == SD - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % ND;
            end else begin
                m_scan++;
            end
            m_sel = n_sel;
            m_seg = n_seg;
            m_carry = 0;
            if (load) begin
                m_val = sanitize(load_val);
                m_pre = 0;
            end else begin
                if (en) m_pre = tick ? 0 : m_pre + 1;
                if (tick && up) begin
                    m_carry = (m_val == MODV - 1);
                    m_val = (m_val + 1) % MODV;
                end else if (tick) begin
                    m_carry = (m_val == 0);
                    m_val = (m_val + MODV - 1) % MODV;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        check("count", 32'(count), 32'(to_bcd(m_val)));
        check("carry", 32'(carry), 32'(m_carry));
        check("sel", 32'(sel), 32'(m_sel));
        check("seg", 32'(seg), 32'(m_seg));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic do_load(input logic [15:0] v);
        load_val = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        int carries;
        reset = 1'b1;
        cyc();
        check("rst_count", 32'(count), 32'h0);
        check("rst_sel", 32'(sel), 32'h1);
        check("rst_seg", 32'(seg), 32'h3F);
        reset = 1'b0;

        en = 1'b1; up = 1'b1;
        carries = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (carry) carries++;
        end
        check("up20_count", 32'(count), 32'h0010);
        check("up20_nocarry", 32'(carries), 32'h0);

        do_load(16'h9998);
        run(2);
        check("r030_9999", 32'(count), 32'h9999);
        run(2);
        check("r030_wrap", 32'(count), 32'h0000);
        check("r030_carry", 32'(carry), 32'h1);
        run(1);
        check("r030_carry_off", 32'(carry), 32'h0);

        do_load(16'h0000);
        up = 1'b0;
        run(2);
        check("r031_9999", 32'(count), 32'h9999);
        check("r031_carry", 32'(carry), 32'h1);
        do_load(16'h12F4);
        check("r031_sanitize", 32'(count), 32'h1204);

        up = 1'b1;
        do_load(16'h0041);
        run(1);
        load_val = 16'h0500;
        load = 1'b1;
        cyc();
        load = 1'b0;
        check("r032_loadwin", 32'(count), 32'h0500);
        check("r032_nocarry", 32'(carry), 32'h0);

        en = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        do_load(16'h0205);
        run(18);
        run(6);
        reset = 1'b1;
        cyc();
        check("midscan_sel", 32'(sel), 32'h1);
        check("midscan_seg", 32'(seg), 32'h3F);
        reset = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            en       = ($urandom_range(3, 0) != 0);
            up       = 1'($urandom_range(1, 0));
            load     = ($urandom_range(31, 0) == 0);
            reset    = ($urandom_range(99, 0) == 0);
            load_val = 16'($urandom);
            cyc();
        end
        reset = 1'b0; load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_bcd_counter.md
SCAN_BCD_COUNTER -- requirements
Module: scan_bcd_counter

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of BCD digits (legal range 1..8).
REQ-002 SHALL have parameter TICK_DIV, default 5000000, CLOCK_50 cycles per count tick (>=1).
REQ-003 SHALL have parameter SCAN_DIV, default 65536, CLOCK_50 cycles per display digit slot (>=1).
REQ-004 SHALL have port CLOCK_50  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  count enable; gates prescaler and counting.
REQ-007 SHALL have port up  input  1  direction: 1 increment, 0 decrement.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  4*N_DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-010 SHALL have port count  output  4*N_DIGITS  registered BCD count, digit 0 least significant.
REQ-011 SHALL have port carry  output  1  one-cycle pulse on wrap in either direction.
REQ-012 SHALL have port sel  output  N_DIGITS  registered one-hot digit select.
REQ-013 SHALL have port seg  output  7  registered active-high segments, bit0=a .. bit6=g, for digit named by sel.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 while en=1, hold while en=0; tick asserted for the one cycle prescaler==TICK_DIV-1 and en=1, then wraps to 0.
REQ-015 On tick with up=1, count SHALL increment in decimal with per-digit carry (9->0, carry into next digit); all-9s -> all-0s with carry=1 next cycle.
REQ-016 On tick with up=0, count SHALL decrement in decimal with per-digit borrow (0->9); all-0s -> all-9s with carry=1 next cycle.
REQ-017 count SHALL update on the clock edge ending the tick cycle (latency 1 from tick); carry SHALL be registered and coincide with the wrapped count value.
REQ-018 load=1 SHALL, next edge, set count=load_val with any digit >9 replaced by 0, clear prescaler to 0, and force carry=0.
REQ-019 load and tick in the same cycle: load SHALL win; no increment, no carry.
REQ-020 Scan counter SHALL free-run 0..SCAN_DIV-1 independent of en and load; at SCAN_DIV-1 digit index SHALL advance 0,1,..,N_DIGITS-1,0.
REQ-021 sel SHALL equal 1<<index and seg SHALL equal decode(count digit index), both updated on the same edge (aligned, 1-cycle latency from count/index).
REQ-022 Decode SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex); no other digit values can occur.
REQ-023 N_DIGITS=1 SHALL hold sel=1 permanently; count wraps 9<->0.

Reset
REQ-024 reset=1 SHALL, next edge, set count=0, carry=0, prescaler=0, scan counter=0, index=0, sel=1, seg=3F, overriding load and en.
REQ-025 reset asserted mid-count or mid-scan SHALL discard all pending ticks; counting resumes from prescaler 0 after release.

Configuration
REQ-026 Macro SCAN_BCD_COUNTER_BLANK_EN SHALL control leading-zero blanking.
REQ-027 With SCAN_BCD_COUNTER_BLANK_EN defined, seg SHALL be 00 for any digit i>0 where digits i..N_DIGITS-1 are all 0; digit 0 never blanked; sel unaffected.
REQ-028 Without SCAN_BCD_COUNTER_BLANK_EN, every digit SHALL be decoded per REQ-022.

Verification (N_DIGITS=4, TICK_DIV=2, SCAN_DIV=4 unless stated)
REQ-029 Reset then en=1,up=1 for 20 cycles -> count 0000,0001,.. advancing every 2 cycles, count=0010 after 20 cycles, carry never set.
REQ-030 load_val=9998, load, then en=1,up=1 -> 9999 after 2 cycles, 0000 with carry=1 for exactly one cycle after 4.
REQ-031 load_val=0000, en=1,up=0 -> 9999 with carry=1 pulse; load_val=12F4 loaded -> count=1204.
REQ-032 load asserted on a tick cycle with count=0041 and load_val=0500 -> count=0500, no 0042, carry=0.
REQ-033 count=0205, scan for 16 cycles -> sel 1,2,4,8 each for 4 cycles with seg 6D,3F,5B,3F (with BLANK_EN: digit 3 seg=00); reset mid-scan -> sel=1, seg=3F next cycle.
